// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: PC sequencing, imem req/ack
// handshake, one-entry skid buffer for stalls, and redirect with stale-response dropping.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        jump,
  input  logic [31:0] redir_pc4,
  input  logic [31:0] br_off,
  input  logic [25:0] jump_idx,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state_q;
  logic [31:0] pc_q, req_addr_q;
  logic [31:0] buf_instr_q, buf_pc4_q;
  logic [31:0] if_instr_q, if_pc4_q;
  logic        if_valid_q, imem_req_q;

  logic        redirect;
  logic [31:0] target, seq_pc;

  always_comb begin
    redirect = jump | br_taken;
    target   = jump ? {redir_pc4[31:28], jump_idx, 2'b00}
                    : redir_pc4 + {br_off[29:0], 2'b00};
    seq_pc   = req_addr_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      if_instr_q  <= '0;
      if_pc4_q    <= '0;
      if_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_addr_q <= pc_q;
          imem_req_q <= 1'b1;
          state_q    <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            // Without an ack the old address must stay on the bus until its response drains.
            pc_q       <= target;
            if_valid_q <= 1'b0;
            if (imem_ack) req_addr_q <= target;
            else          state_q    <= DROP;
          end else if (imem_ack && stall) begin
            buf_instr_q <= imem_rdata;
            buf_pc4_q   <= seq_pc;
            pc_q        <= seq_pc;
            imem_req_q  <= 1'b0;
            state_q     <= HOLD;
          end else if (imem_ack) begin
            if_instr_q <= imem_rdata;
            if_pc4_q   <= seq_pc;
            if_valid_q <= 1'b1;
            pc_q       <= seq_pc;
            req_addr_q <= seq_pc;
          end else if (!stall) begin
            if_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_q       <= target;
            req_addr_q <= target;
            if_valid_q <= 1'b0;
            imem_req_q <= 1'b1;
            state_q    <= FETCH;
          end else if (!stall) begin
            if_instr_q <= buf_instr_q;
            if_pc4_q   <= buf_pc4_q;
            if_valid_q <= 1'b1;
            req_addr_q <= pc_q;
            imem_req_q <= 1'b1;
            state_q    <= FETCH;
          end
        end
        DROP: begin
          // A redirect coinciding with the stale ack goes straight to the new target.
          if (imem_ack) begin
            pc_q       <= redirect ? target : pc_q;
            req_addr_q <= redirect ? target : pc_q;
            state_q    <= FETCH;
          end else if (redirect) begin
            pc_q <= target;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = req_addr_q;
  assign if_instr  = if_instr_q;
  assign if_pc4    = if_pc4_q;
  assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level reference model plus directed scenarios
// and a randomized phase with variable memory latency, stalls and redirects.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jump;
  logic [31:0] redir_pc4, br_off;
  logic [25:0] jump_idx;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc4;
  logic        if_valid;

  logic        req2, ack2, valid2;
  logic [31:0] addr2, rdata2, instr2, pc4_2;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: bus request, stale-response flag, start-up cycle, skid queue.
  logic        m_req, m_stale, m_boot, m_valid;
  logic [31:0] m_pc, m_addr, m_instr, m_pc4;
  logic [63:0] skid[$];

  int unsigned mem_cnt, lat_lo, lat_hi;
  logic        force_ack;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .jump(jump),
    .redir_pc4(redir_pc4), .br_off(br_off), .jump_idx(jump_idx),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_instr(if_instr), .if_pc4(if_pc4), .if_valid(if_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_top (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .jump(jump),
    .redir_pc4(redir_pc4), .br_off(br_off), .jump_idx(jump_idx),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata2), .if_instr(instr2), .if_pc4(pc4_2), .if_valid(valid2)
  );

  always #5 clk = ~clk;

  assign ack2   = 1'b1;
  assign rdata2 = word(addr2);

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16]} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_stale = 0; m_boot = 1; m_valid = 0;
    m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    skid.delete();
    mem_cnt = $urandom_range(lat_hi, lat_lo);
  endtask

  task automatic model_edge(input logic a);
    logic [31:0] tgt;
    logic        redir;
    redir = jump | br_taken;
    tgt   = jump ? {redir_pc4[31:28], jump_idx, 2'b00} : redir_pc4 + br_off * 32'd4;
    if (rst) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 0; m_req = 1; m_addr = m_pc;
    end else if (m_req && !m_stale) begin
      if (redir) begin
        m_pc = tgt; m_valid = 0;
        if (a) m_addr = tgt; else m_stale = 1;
      end else if (a && stall) begin
        skid.push_back({imem_rdata, m_addr + 32'd4});
        m_pc = m_addr + 32'd4; m_req = 0;
      end else if (a) begin
        m_instr = imem_rdata; m_pc4 = m_addr + 32'd4; m_valid = 1;
        m_addr = m_addr + 32'd4; m_pc = m_addr;
      end else if (!stall) begin
        m_valid = 0;
      end
    end else if (m_req) begin
      if (redir) m_pc = tgt;
      if (a) begin m_stale = 0; m_addr = m_pc; end
    end else begin
      if (redir) begin
        skid.delete(); m_pc = tgt; m_addr = tgt; m_req = 1; m_valid = 0;
      end else if (!stall) begin
        {m_instr, m_pc4} = skid.pop_front();
        m_valid = 1; m_addr = m_pc; m_req = 1;
      end
    end
  endtask

  // One clock: memory drives ack from the model's view of the bus, then model and DUT are compared.
  task automatic step();
    logic a, was_req;
    was_req    = m_req;
    a          = m_req && (mem_cnt == 0);
    imem_ack   = a | force_ack;
    imem_rdata = a ? word(m_addr) : $urandom;
    @(posedge clk);
    model_edge(a);
    if (!rst) begin
      if (was_req && a)                 mem_cnt = $urandom_range(lat_hi, lat_lo);
      else if (was_req && mem_cnt > 0)  mem_cnt--;
    end
    #1;
    chk("imem_req",  imem_req,  m_req);
    chk("imem_addr", imem_addr, m_addr);
    chk("if_valid",  if_valid,  m_valid);
    chk("if_instr",  if_instr,  m_instr);
    chk("if_pc4",    if_pc4,    m_pc4);
  endtask

  task automatic clear_ctl();
    stall = 0; br_taken = 0; jump = 0; force_ack = 0;
  endtask

  initial begin
    logic [31:0] old;
    int unsigned n;
    logic [15:0] r;
    rst = 1; clear_ctl();
    redir_pc4 = '0; br_off = '0; jump_idx = '0; imem_ack = 0; imem_rdata = '0;
    lat_lo = 0; lat_hi = 0;
    model_reset();

    // Reset values
    step(); step();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_top_addr", addr2, 32'hFFFF_FFF8);

    // Zero-wait fetch, and the wrap of the high-PC instance
    rst = 0;
    step();
    chk("first_req", imem_req, 1'b1);
    chk("top_a0", addr2, 32'hFFFF_FFF8);
    step();
    chk("top_a1", addr2, 32'hFFFF_FFFC);
    chk("zw_instr0", if_instr, word(32'h0));
    step();
    chk("top_a2", addr2, 32'h0000_0000);
    chk("zw_pc4", if_pc4, 32'h8);
    chk("zw_addr", imem_addr, 32'h8);

    // Stall while 0x10 is acked
    n = 0;
    while (m_addr != 32'h10 && n < 20) begin step(); n++; end
    chk("reach_0x10", imem_addr, 32'h10);
    stall = 1;
    step(); step(); step();
    chk("stall_hold", if_instr, word(32'h0C));
    chk("stall_noreq", imem_req, 1'b0);
    stall = 0;
    step();
    chk("release_instr", if_instr, word(32'h10));
    chk("release_addr", imem_addr, 32'h14);

    // Branch before ack with 2-cycle latency
    mem_cnt = 2;
    old = m_addr;
    br_taken = 1; redir_pc4 = 32'h20; br_off = 32'hFFFF_FFFC;
    step();
    br_taken = 0;
    chk("drop_hold0", imem_addr, old);
    step();
    chk("drop_hold1", imem_addr, old);
    chk("drop_bubble", if_valid, 1'b0);
    step();
    chk("br_target", imem_addr, 32'h10);
    chk("br_bubble", if_valid, 1'b0);

    // Jump has priority over branch
    jump = 1; br_taken = 1; redir_pc4 = 32'h4000_0010; jump_idx = 26'h0000_100; br_off = 32'h7;
    step();
    clear_ctl();
    chk("jump_wins", imem_addr, 32'h4000_0400);
    step();

    // Reset during DROP with a late ack
    mem_cnt = 3;
    br_taken = 1; redir_pc4 = 32'h100; br_off = 32'h4;
    step();
    br_taken = 0;
    step();
    rst = 1; force_ack = 1;
    step();
    chk("rst_drop_valid", if_valid, 1'b0);
    chk("rst_drop_addr", imem_addr, 32'h0);
    rst = 0;
    step();
    force_ack = 0;
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // Randomized traffic
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 400; i++) begin
      stall     = ($urandom % 4) == 0;
      jump      = ($urandom % 16) == 0;
      br_taken  = ($urandom % 8) == 0;
      redir_pc4 = $urandom & 32'hFFFF_FFFC;
      r         = 16'($urandom);
      br_off    = {{16{r[15]}}, r};
      jump_idx  = 26'($urandom);
      rst       = ($urandom % 100) == 0;
      force_ack = m_boot && (($urandom % 2) == 0);
      step();
    end
    clear_ctl(); rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
